// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-outstanding APB master bridging a valid/ready command/response port.
// Every output is a flop; a stalled access is aborted with an error after TIMEOUT wait cycles.
module apb_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              rst_n,
  // local command / response port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB master port
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // state  | meaning
  // IDLE   | cmd_ready high, waiting for a command handshake
  // SETUP  | psel high, penable low, one cycle
  // ACCESS | psel/penable high, waiting for pready or timeout
  // RESP   | rsp_valid high until the requester accepts it
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Wide enough to hold TIMEOUT itself without wrapping.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    wait_inc;
  logic                cmd_ready_q, cmd_ready_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                cmd_hs;
  logic                access_done;
  logic                timeout_hit;

  assign cmd_hs      = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  assign wait_inc    = wait_cnt_q + CNT_W'(1);
  assign access_done = (state_q == ACCESS) && pready;
  assign timeout_hit = (state_q == ACCESS) && !pready && (wait_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_hs) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (access_done || timeout_hit) state_d = RESP;
      RESP:    if (rsp_valid_q && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output flops are loaded from the next state so each one changes on the same edge as the FSM.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);

    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    if (cmd_hs) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_write ? cmd_wdata : '0;
    end

    wait_cnt_d = wait_cnt_q;
    if (cmd_hs) begin
      wait_cnt_d = '0;
    end else if ((state_q == ACCESS) && !pready) begin
      wait_cnt_d = wait_inc;
    end

    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (access_done) begin
      rsp_rdata_d = pwrite_q ? '0 : prdata;
      rsp_err_d   = pslverr;
    end else if (timeout_hit) begin
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed and random transfers against a behavioural APB slave and
// transaction-level expectations (latency, response, bus stability, reset behaviour).
module tb_apb_master_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, paddr;
  logic [DW-1:0] cmd_wdata, rsp_rdata, pwdata, prdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic          pwrite, psel, penable, pready, pslverr;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc_cnt = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];

  apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // Random slave-side values the master must ignore.
  task automatic noise();
    pready  = 1'($urandom_range(0, 1));
    pslverr = 1'($urandom_range(0, 1));
    prdata  = $urandom;
  endtask

  // Called at a negedge; returns at the negedge after the response is accepted.
  task automatic txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input int waits, input logic serr, input int bp,
                     output int unsigned hs_cyc);
    logic          tmo, exp_err;
    logic [DW-1:0] exp_rd, exp_pwd;
    int            cyc, acc, pen, exp_lat, exp_pen;
    tmo     = (waits >= TO);
    exp_err = tmo | serr;
    exp_rd  = (tmo || wr) ? '0 : mem_rd(addr);
    exp_pwd = wr ? wd : '0;
    exp_lat = tmo ? TO + 2 : waits + 3;
    exp_pen = tmo ? TO : waits + 1;
    rsp_ready = (bp == 0);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    noise();
    @(negedge pclk);
    hs_cyc    = cyc_cnt;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cyc = 1; acc = 0; pen = 0;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    while (!rsp_valid && cyc < 40) begin
      chk("penable_without_psel", penable & ~psel, 0);
      chk("cmd_ready_busy", cmd_ready, 0);
      if (psel) begin
        chk("paddr_stable", paddr, addr);
        chk("pwrite_stable", pwrite, wr);
        chk("pwdata_stable", pwdata, exp_pwd);
      end
      if (penable) begin
        pen++; acc++;
        if (acc == waits + 1) begin
          pready  = 1'b1;
          pslverr = serr;
          prdata  = wr ? $urandom : mem_rd(addr);
          if (wr && !serr) mem[addr] = wd;
        end else begin
          pready  = 1'b0;
          pslverr = 1'($urandom_range(0, 1));
          prdata  = $urandom;
        end
      end else begin
        noise();
      end
      @(negedge pclk);
      cyc++;
    end
    if (!rsp_valid) begin
      chk("rsp_within_budget", 0, 1);
      return;
    end
    chk("rsp_latency", cyc, exp_lat);
    chk("penable_cycles", pen, exp_pen);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("resp_psel", psel, 0);
    chk("resp_penable", penable, 0);
    chk("resp_cmd_ready", cmd_ready, 0);
    noise();
    for (int k = 0; k < bp; k++) begin
      @(negedge pclk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_err", rsp_err, exp_err);
      chk("bp_rsp_rdata", rsp_rdata, exp_rd);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_psel", psel, 0);
      noise();
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    chk("rsp_accepted", rsp_valid, 0);
    chk("cmd_ready_after_rsp", cmd_ready, 1);
  endtask

  initial begin
    int unsigned   h1, h2;
    logic          r_wr, r_serr;
    logic [AW-1:0] r_addr;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    #1;
    chk("cmd_ready_before_first_edge", cmd_ready, 0);
    @(negedge pclk);
    chk("cmd_ready_after_release", cmd_ready, 1);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 0, h1);
    chk("slave_mem_0x10", mem_rd(32'h10), 32'hDEADBEEF);
    txn(1'b0, 32'h10, 32'h0, 0, 1'b0, 0, h2);
    chk("back_to_back_gap", h2 - h1, 4);

    txn(1'b1, 32'h14, 32'hCAFE0001, 4, 1'b0, 0, h1);
    txn(1'b1, 32'h14, 32'hA5A5_5A5A, 3, 1'b0, 0, h1);
    txn(1'b0, 32'h14, 32'h0, 12, 1'b0, 1, h1);
    txn(1'b0, 32'h14, 32'h0, 0, 1'b1, 5, h1);
    txn(1'b0, 32'h14, 32'h0, 2, 1'b0, 0, h1);

    // Reset in the middle of an ACCESS phase.
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h1234_5678;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("pre_reset_penable", penable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_psel", psel, 0);
    chk("async_rst_penable", penable, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    @(negedge pclk);
    rst_n = 1'b1;
    noise();
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_psel", psel, 0);
      noise();
    end
    txn(1'b0, 32'h20, 32'h0, 1, 1'b0, 0, h1);

    for (int i = 0; i < 25; i++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      r_serr = ($urandom_range(0, 3) == 0);
      txn(r_wr, r_addr, $urandom, int'($urandom_range(0, 5)), r_serr,
          int'($urandom_range(0, 2)), h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameter: ADDR_W, 32, address width of command and APB address.
REQ-002 Parameter: DATA_W, 32, data width of command, response and APB data.
REQ-003 Parameter: TIMEOUT, 16, maximum ACCESS cycles without pready before abort; legal range 1..65535.
REQ-004 pclk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command request from local requester.
REQ-007 cmd_ready  out  1  block can accept a command this cycle.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_W  target address.
REQ-010 cmd_wdata  in  DATA_W  write data; ignored for reads.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  requester accepts response.
REQ-013 rsp_rdata  out  DATA_W  read data; 0 for writes and for aborted transfers.
REQ-014 rsp_err  out  1  slave error or timeout.
REQ-015 paddr / pwrite / pwdata  out  ADDR_W / 1 / DATA_W  APB address, direction, write data to slave.
REQ-016 psel / penable  out  1 / 1  APB select and enable to slave.
REQ-017 prdata / pready / pslverr  in  DATA_W / 1 / 1  APB read data, ready, error from slave.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS, RESP; all outputs driven from registers, no combinational path from any input to any output.
REQ-019 cmd_ready = 1 only in IDLE; handshake = cmd_valid && cmd_ready at a rising edge; the command is latched and the FSM goes IDLE -> SETUP.
REQ-020 SETUP: psel=1, penable=0, paddr/pwrite taken from the latched command, pwdata = cmd_wdata for writes and 0 for reads; unconditional transition to ACCESS after one cycle.
REQ-021 ACCESS: psel=1, penable=1; paddr, pwrite and pwdata held bit-stable from SETUP until leaving ACCESS.
REQ-022 ACCESS with pready=1 at an edge: capture prdata (reads only; writes capture 0) into rsp_rdata, capture pslverr into rsp_err, deassert psel/penable, go to RESP.
REQ-023 ACCESS with pready=0: increment a wait counter; when the counter reaches TIMEOUT, abort: psel/penable=0, rsp_rdata=0, rsp_err=1, go to RESP.
REQ-024 The wait counter clears on entry to SETUP; it is wide enough to count TIMEOUT without wrap.
REQ-025 RESP: rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_valid && rsp_ready at an edge; then go to IDLE, rsp_valid=0.
REQ-026 Latency: command accepted at edge N -> psel=1 after N, penable=1 after N+1, rsp_valid=1 after N+2 at the earliest (zero-wait slave).
REQ-027 Back-to-back: minimum 4 cycles between consecutive command handshakes with rsp_ready held 1; the block never issues a second APB transfer before the previous response is accepted.
REQ-028 pslverr and prdata are sampled only in ACCESS when pready=1; their values at all other times are ignored.
REQ-029 psel=0 implies penable=0 at all times.

Reset
REQ-030 rst_n low asynchronously forces IDLE; psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, cmd_ready=0 while rst_n=0 and 1 from the first edge after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
REQ-031 Reset during SETUP, ACCESS or RESP discards the in-flight command; no response is produced for it after reset release.

Verification
REQ-032 Write, zero-wait slave: cmd write addr 0x10, data 0xDEADBEEF -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid with rsp_err=0, rsp_rdata=0; slave memory at 0x10 = 0xDEADBEEF.
REQ-033 Read back addr 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, pwdata=0 throughout the transfer.
REQ-034 Wait states: pready held 0 for 3 ACCESS cycles, then 1 -> penable high 4 cycles, paddr/pwdata stable throughout, single response.
REQ-035 Timeout: TIMEOUT=4, pready stuck 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0, psel=0.
REQ-036 Slave error plus backpressure: pslverr=1 with pready=1, rsp_ready held 0 for 5 cycles -> rsp_valid held 5 cycles, rsp_err=1 stable, cmd_ready=0 until rsp_valid && rsp_ready.
REQ-037 Reset mid-ACCESS: rst_n pulsed low during ACCESS -> psel/penable low immediately with no clock edge, no rsp_valid after reset release, next command completes normally.
